// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin share of one W-bit logic-op unit (d = a & (b | c), r = a & b) among N requesters
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester level request, dropped after its gnt bit is seen
//   op_a/b/c   packed operands, requester i owns bits [i*W +: W]
//   gnt        one-hot single-cycle pulse: that requester's operands were captured
//   res_valid  result available, held until res_ready
//   res_ready  consumer accepts the result
//   res_id     index of the requester owning the result
//   res_d      a & (b | c)
//   res_r      a & b
module logic_op_arbiter #(
    parameter int W    = 4,
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  op_a,
    input  logic [N*W-1:0]  op_b,
    input  logic [N*W-1:0]  op_c,
    output logic [N-1:0]    gnt,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ID_W-1:0] res_id,
    output logic [W-1:0]    res_d,
    output logic [W-1:0]    res_r
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    state_t          r_state;
    state_t          w_next;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_c;
    logic [ID_W-1:0] w_win;
    logic [ID_W-1:0] w_next_ptr;
    logic            w_grant;
    logic            w_calc;
    logic            w_done;
    // Scan downward from ptr+N-1 to ptr so the requester closest to ptr is the last assignment and wins
    always_comb begin
        w_win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_ptr) + k) % N;
            if (req[idx]) w_win = ID_W'(idx);
        end
    end
    assign w_next_ptr = (w_win == ID_W'(N - 1)) ? '0 : w_win + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = (|req) ? CALC : IDLE;
            CALC:    w_next = RESP;
            RESP:    w_next = res_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        w_grant = (r_state == IDLE) && (|req);
        w_calc  = (r_state == CALC);
        w_done  = (r_state == RESP) && res_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_d     <= '0;
            res_r     <= '0;
            r_ptr     <= '0;
            r_id      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
        end else begin
            gnt <= w_grant ? (N'(1) << w_win) : '0;
            if (w_grant) begin
                r_a   <= op_a[w_win*W +: W];
                r_b   <= op_b[w_win*W +: W];
                r_c   <= op_c[w_win*W +: W];
                r_id  <= w_win;
                r_ptr <= w_next_ptr;
            end
            if (w_calc) begin
                res_d     <= r_a & (r_b | r_c);
                res_r     <= r_a & r_b;
                res_id    <= r_id;
                res_valid <= 1'b1;
            end else if (w_done) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed table and sequence checks for logic_op_arbiter
module tb_logic_op_arbiter;
    localparam int W = 4, N = 3, ID_W = 2;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  op_a = '0, op_b = '0, op_c = '0;
    logic            res_ready = 1'b0;
    logic [N-1:0]    gnt;
    logic            res_valid;
    logic [ID_W-1:0] res_id;
    logic [W-1:0]    res_d, res_r;
    int errs = 0, checks = 0;

    logic_op_arbiter #(.W(W), .N(N), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_d(res_d), .res_r(res_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    req;
        logic [N*W-1:0]  a, b, c;
        logic            rdy;
        logic [N-1:0]    gnt;
        logic            v;
        logic [ID_W-1:0] id;
        logic [W-1:0]    d, r;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] g, input logic [31:0] v,
                             input logic [31:0] id, input logic [31:0] d, input logic [31:0] r);
        chk({tag, ".gnt"}, 32'(gnt), g);
        chk({tag, ".valid"}, 32'(res_valid), v);
        chk({tag, ".id"}, 32'(res_id), id);
        chk({tag, ".d"}, 32'(res_d), d);
        chk({tag, ".r"}, 32'(res_r), r);
    endtask

    initial begin
        logic [W-1:0] ea, eb, ec;
        int g, ph;
        tbl[0] = '{3'b010, 12'h0F0, 12'h030, 12'h080, 1'b1, 3'b010, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[1] = '{3'b000, 12'h000, 12'h000, 12'h000, 1'b1, 3'b000, 1'b1, 2'd1, 4'hB, 4'h3};
        tbl[2] = '{3'b000, 12'h000, 12'h000, 12'h000, 1'b1, 3'b000, 1'b0, 2'd1, 4'hB, 4'h3};
        tbl[3] = '{3'b000, 12'h000, 12'h000, 12'h000, 1'b1, 3'b000, 1'b0, 2'd1, 4'hB, 4'h3};
        tbl[4] = '{3'b011, 12'h0FC, 12'h03A, 12'h085, 1'b1, 3'b001, 1'b0, 2'd1, 4'hB, 4'h3};
        tbl[5] = '{3'b000, 12'h000, 12'h000, 12'h000, 1'b1, 3'b000, 1'b1, 2'd0, 4'hC, 4'h8};
        tbl[6] = '{3'b000, 12'h000, 12'h000, 12'h000, 1'b0, 3'b000, 1'b1, 2'd0, 4'hC, 4'h8};
        tbl[7] = '{3'b000, 12'h000, 12'h000, 12'h000, 1'b1, 3'b000, 1'b0, 2'd0, 4'hC, 4'h8};

        // reset held while requests are pending and the clock runs
        req = 3'b111;
        res_ready = 1'b1;
        op_a = 12'h111; op_b = 12'h111; op_c = 12'h111;
        repeat (4) begin
            @(negedge clk);
            check_out("reset", 0, 0, 0, 0, 0);
        end
        rst_n = 1'b1;
        op_a = '0; op_b = '0; op_c = '0;
        @(negedge clk);
        chk("first_grant", 32'(gnt), 32'b001);
        req = '0;
        @(negedge clk);
        check_out("first_res", 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("first_done", 32'(res_valid), 0);

        // table: single request, operand change after capture, idle, wrap/skip, hold
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req; op_a = tbl[i].a; op_b = tbl[i].b; op_c = tbl[i].c; res_ready = tbl[i].rdy;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].v, tbl[i].id, tbl[i].d, tbl[i].r);
        end

        // backpressure with a competing request raised while the result waits
        req = 3'b010; op_a = 12'h0F0; op_b = 12'h030; op_c = 12'h080; res_ready = 1'b0;
        @(negedge clk);
        chk("bp_gnt", 32'(gnt), 32'b010);
        req = '0;
        @(negedge clk);
        check_out("bp_res", 0, 1, 1, 4'hB, 4'h3);
        req = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_out($sformatf("bp_hold%0d", i), 0, 1, 1, 4'hB, 4'h3);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check_out("bp_hs", 0, 0, 1, 4'hB, 4'h3);
        @(negedge clk);
        chk("bp_next_gnt", 32'(gnt), 32'b001);
        req = '0;
        @(negedge clk);
        @(negedge clk);

        // round robin from a fresh reset with all requesters asserting continuously
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        op_a = 12'h7E3; op_b = 12'h5C6; op_c = 12'h29A;
        req = 3'b111; res_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            ph = k % 3;
            g = (k / 3) % 3;
            chk($sformatf("rr%0d.gnt", k), 32'(gnt), (ph == 0) ? (32'd1 << g) : 32'd0);
            chk($sformatf("rr%0d.valid", k), 32'(res_valid), (ph == 1) ? 32'd1 : 32'd0);
            if (ph == 1) begin
                ea = op_a[g*W +: W]; eb = op_b[g*W +: W]; ec = op_c[g*W +: W];
                chk($sformatf("rr%0d.id", k), 32'(res_id), 32'(g));
                chk($sformatf("rr%0d.d", k), 32'(res_d), 32'(ea & (eb | ec)));
                chk($sformatf("rr%0d.r", k), 32'(res_r), 32'(ea & eb));
            end
        end

        // reset during RESP discards the result and returns ptr to 0
        req = 3'b010; res_ready = 1'b0;
        @(negedge clk);
        chk("mr_gnt", 32'(gnt), 32'b010);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_valid_before", 32'(res_valid), 1);
        #2 rst_n = 1'b0;
        #1 check_out("mr_async", 0, 0, 0, 0, 0);
        @(negedge clk);
        check_out("mr_held", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        req = 3'b110; res_ready = 1'b1;
        @(negedge clk);
        chk("mr_after_gnt", 32'(gnt), 32'b010);
        req = '0;
        @(negedge clk);
        chk("mr_after_id", 32'(res_id), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
